// File: rtl/instr_pkg.sv
// Shared definitions for the 3-bit instruction-code interface: field widths,
// the tuple <-> code map used by both encode and decode stages, and FSM states.
package instr_pkg;

    localparam int REG_W     = 3;
    localparam int CMD_W     = 4;
    localparam int CODE_W    = 3;
    localparam int NUM_CODES = 1 << CODE_W;
    localparam int GAP_W     = 4;

    typedef struct packed {
        logic [REG_W-1:0] src_reg1;
        logic [REG_W-1:0] src_reg2;
        logic [CMD_W-1:0] cmd;
        logic [REG_W-1:0] dest_reg;
    } instr_tuple_t;

    localparam int TUPLE_W = $bits(instr_tuple_t);

    typedef struct packed {
        logic              hit;
        logic [CODE_W-1:0] code;
    } lookup_t;

    typedef enum logic {
        ST_IDLE,
        ST_GAP
    } state_t;

    // Index in this table is the code; the decode stage reads the same table.
    localparam instr_tuple_t CODE_TUPLE [NUM_CODES] = '{
        {3'b010, 3'b011, 4'b0000, 3'b001},
        {3'b001, 3'b101, 4'b0001, 3'b100},
        {3'b001, 3'b010, 4'b1010, 3'b010},
        {3'b001, 3'b010, 4'b1011, 3'b111},
        {3'b001, 3'b010, 4'b0010, 3'b110},
        {3'b001, 3'b010, 4'b0100, 3'b001},
        {3'b010, 3'b000, 4'b1000, 3'b011},
        {3'b000, 3'b000, 4'b1000, 3'b110}
    };

    function automatic lookup_t encode_lookup(input instr_tuple_t t);
        lookup_t r;
        // NOTE: default every combinational result up front so no path leaves it unassigned (no latch).
        r = '0;
        for (int i = 0; i < NUM_CODES; i++) begin
            if (t == CODE_TUPLE[i]) begin
                r.hit  = 1'b1;
                r.code = CODE_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/instr_encode_if.sv
// Tuple input handshake plus code/strobe/error outputs of the instruction encoder.
interface instr_encode_if;
    import instr_pkg::*;

    logic              IN_VALID;
    logic              IN_READY;
    logic [REG_W-1:0]  SRC_REG1;
    logic [REG_W-1:0]  SRC_REG2;
    logic [CMD_W-1:0]  CMD;
    logic [REG_W-1:0]  DEST_REG;
    logic              HOLD;
    logic [CODE_W-1:0] C;
    logic              EN;
    logic              ERR;
    logic [7:0]        ERR_CNT;

    modport master (
        output IN_VALID, SRC_REG1, SRC_REG2, CMD, DEST_REG, HOLD,
        input  IN_READY, C, EN, ERR, ERR_CNT
    );

    modport slave (
        input  IN_VALID, SRC_REG1, SRC_REG2, CMD, DEST_REG, HOLD,
        output IN_READY, C, EN, ERR, ERR_CNT
    );

endinterface

// File: rtl/instr_fifo.sv
// Synchronous circular-buffer FIFO; pointers carry one extra wrap bit so
// full and empty are distinguished without a separate count.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; clearing the pointers already empties the FIFO and keeps this a plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/instr_encode.sv
// Instruction issue encoder: FIFO-buffered tuples reverse-mapped to 3-bit codes
// and issued with an EN strobe. Define INSTR_ENCODE_ERRCNT_EN to build ERR_CNT.
module instr_encode
    import instr_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_encode_if.slave  bus
);

    instr_tuple_t      w_in_tuple;
    instr_tuple_t      w_head;
    lookup_t           w_lookup;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_drop;

    state_t            r_state;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [CODE_W-1:0] r_code;
    logic              r_en;
    logic              r_err;

    assign w_in_tuple = '{src_reg1: bus.SRC_REG1, src_reg2: bus.SRC_REG2,
                          cmd: bus.CMD, dest_reg: bus.DEST_REG};

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TUPLE_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.IN_VALID),
        .i_pop   (w_pop),
        .i_data  (w_in_tuple),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A pop happens for both issues and drops; the lookup decides which.
    assign w_lookup = encode_lookup(w_head);
    assign w_pop    = (r_state == ST_IDLE) && !w_empty && !bus.HOLD;
    assign w_drop   = w_pop && !w_lookup.hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
            r_code    <= '0;
            r_en      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_en  <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        if (w_lookup.hit) begin
                            r_code <= w_lookup.code;
                            r_en   <= 1'b1;
                            if (GAP_CYCLES > 0) begin
                                r_state   <= ST_GAP;
                                r_gap_cnt <= GAP_W'(GAP_CYCLES);
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt <= GAP_W'(1)) r_state <= ST_IDLE;
                    else                        r_gap_cnt <= r_gap_cnt - 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.IN_READY = !w_full;
    assign bus.C        = r_code;
    assign bus.EN       = r_en;
    assign bus.ERR      = r_err;

`ifdef INSTR_ENCODE_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           r_err_cnt <= '0;
        else if (w_drop && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign bus.ERR_CNT = r_err_cnt;
`else
    assign bus.ERR_CNT = '0;
`endif

endmodule
